// File: rtl/psram_spi_ctrl_pkg.sv
// Shared definitions for the SPI-mode PSRAM controller.
// Provides the device opcodes, the controller state encoding and the dummy-cycle count.
package psram_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_RSTEN     = 8'h66;
    localparam logic [7:0] OP_RST       = 8'h99;

    localparam int DUMMY_BITS = 8;

    // ST_TAIL is the one clk between the last sclk fall and ce going high
    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_RSTEN,
        ST_CEGAP,
        ST_RST,
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_TAIL
    } state_t;

endpackage

// File: rtl/psram_spi_ctrl_if.sv
// Request/response bus between the system-side requester and the PSRAM controller.
// The requester uses the master modport, the controller the slave modport.
interface psram_spi_ctrl_if #(
    parameter int ADDR_W      = 24,
    parameter int BURST_BYTES = 12
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDR_W-1:0]        req_addr;
    logic [8*BURST_BYTES-1:0] req_wdata;
    logic                     rsp_valid;
    logic [8*BURST_BYTES-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/psram_spi_ctrl_sclk_gen.sv
// SPI clock divider for the PSRAM controller.
// Produces a mode-0 sclk (idle low) toggling every CLK_DIV clk while enabled, plus
// combinational strobes that are high in the clk cycle whose closing edge makes sclk rise/fall.
module psram_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] div_cnt;
    logic             tick;

    assign tick     = en && (div_cnt == CNT_W'(CLK_DIV - 1));
    assign rise_stb = tick && !sclk;
    assign fall_stb = tick && sclk;

    // Half-period counter; disabling returns sclk low and restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/psram_spi_ctrl.sv
// SPI-mode PSRAM controller: power-up reset sequence, then single-burst reads and writes.
// Optional feature macro: PSRAM_FAST_READ_EN (reads use 0x0B with 8 dummy sclk cycles).
// The whole frame (opcode, address, optional dummy, data) is loaded into one shift register
// at accept; mosi is its MSB, shifted on every sclk fall.
module psram_spi_ctrl
    import psram_pkg::*;
#(
    parameter int BURST_BYTES    = 12,
    parameter int ADDR_W         = 24,
    parameter int CLK_DIV        = 2,
    parameter int INIT_CYCLES    = 15000,
    parameter int CE_HIGH_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    psram_spi_ctrl_if.slave    bus,
    output logic               init_done,
    output logic               ce,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso
);

`ifdef PSRAM_FAST_READ_EN
    localparam bit         FAST_READ = 1'b1;
    localparam logic [7:0] READ_OP   = OP_FAST_READ;
`else
    localparam bit         FAST_READ = 1'b0;
    localparam logic [7:0] READ_OP   = OP_READ;
`endif

    localparam int DATA_W = 8 * BURST_BYTES;
    localparam int TX_W   = 8 + ADDR_W + DUMMY_BITS + DATA_W;
    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int GAP_W  = $clog2(CE_HIGH_CYCLES + 1);

    state_t             state;
    state_t             next_state;
    logic [INIT_W-1:0]  init_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [15:0]        bit_cnt;
    logic [15:0]        phase_len;
    logic [TX_W-1:0]    tx_sr;
    logic [DATA_W-1:0]  rx_sr;
    logic               cur_write;
    logic               xfer_active;
    logic               rst_sent;
    logic               sclk_en;
    logic               rise_stb;
    logic               fall_stb;
    logic               last_bit;

    psram_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (sclk_en),
        .sclk     (sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    assign mosi     = tx_sr[TX_W-1];
    assign last_bit = fall_stb && (bit_cnt == phase_len - 16'd1);

    // Number of SPI bits in the phase the FSM is currently in
    always_comb begin
        phase_len = 16'd8;
        case (state)
            ST_ADDR: phase_len = 16'(ADDR_W);
            ST_WAIT: phase_len = 16'(DUMMY_BITS);
            ST_DATA: phase_len = 16'(DATA_W);
            default: phase_len = 16'd8;
        endcase
    end

    // State register; reset always restarts the power-up sequence
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT_WAIT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: phases advance on the sclk fall that ends their last bit
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT_WAIT: if (init_cnt == INIT_W'(INIT_CYCLES - 1)) next_state = ST_RSTEN;
            ST_RSTEN,
            ST_RST,
            ST_DATA:      if (last_bit) next_state = ST_TAIL;
            ST_TAIL:      next_state = ST_CEGAP;
            ST_CEGAP:     if (gap_cnt == GAP_W'(CE_HIGH_CYCLES - 1))
                              next_state = rst_sent ? ST_IDLE : ST_RST;
            ST_IDLE:      if (bus.req_valid) next_state = ST_CMD;
            ST_CMD:       if (last_bit) next_state = ST_ADDR;
            ST_ADDR:      if (last_bit)
                              next_state = (FAST_READ && !cur_write) ? ST_WAIT : ST_DATA;
            ST_WAIT:      if (last_bit) next_state = ST_DATA;
            default:      next_state = ST_INIT_WAIT;
        endcase
    end

    // Decoded outputs: ce low for the frame plus its tail clk, sclk runs only inside the frame
    always_comb begin
        ce            = 1'b1;
        sclk_en       = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            ST_RSTEN, ST_RST, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA: begin
                ce      = 1'b0;
                sclk_en = 1'b1;
            end
            ST_TAIL:  ce = 1'b0;
            ST_IDLE:  bus.req_ready = 1'b1;
            default:  ;
        endcase
    end

    // Counters, shift registers, request latching and the response pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt      <= '0;
            gap_cnt       <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            cur_write     <= 1'b0;
            xfer_active   <= 1'b0;
            rst_sent      <= 1'b0;
            init_done     <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;

            if (state == ST_INIT_WAIT) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end

            if (state == ST_CEGAP) begin
                gap_cnt <= (next_state != ST_CEGAP) ? '0 : gap_cnt + GAP_W'(1);
            end

            if (fall_stb) begin
                bit_cnt <= last_bit ? 16'd0 : bit_cnt + 16'd1;
            end

            if (state == ST_INIT_WAIT && next_state == ST_RSTEN) begin
                tx_sr <= {OP_RSTEN, {(TX_W-8){1'b0}}};
            end else if (state == ST_CEGAP && next_state == ST_RST) begin
                tx_sr <= {OP_RST, {(TX_W-8){1'b0}}};
            end else if (state == ST_IDLE && bus.req_valid) begin
                if (bus.req_write) begin
                    tx_sr <= {OP_WRITE, bus.req_addr, bus.req_wdata, {DUMMY_BITS{1'b0}}};
                end else begin
                    tx_sr <= {READ_OP, bus.req_addr, {(DUMMY_BITS+DATA_W){1'b0}}};
                end
            end else if (fall_stb) begin
                tx_sr <= {tx_sr[TX_W-2:0], 1'b0};
            end

            if (state == ST_IDLE && bus.req_valid) begin
                cur_write   <= bus.req_write;
                xfer_active <= 1'b1;
            end

            if (state == ST_DATA && rise_stb && !cur_write) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end

            if (state == ST_RST && last_bit) begin
                rst_sent <= 1'b1;
            end

            if (state == ST_TAIL && xfer_active) begin
                bus.rsp_valid <= 1'b1;
                xfer_active   <= 1'b0;
                if (!cur_write) begin
                    bus.rsp_rdata <= rx_sr;
                end
            end

            if (next_state == ST_IDLE) begin
                init_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psram_spi_ctrl.sv
// Directed testbench for psram_spi_ctrl with a behavioural 1 KiB-page PSRAM model.
// Build with or without PSRAM_FAST_READ_EN; read expectations follow the macro.
module tb_psram_spi_ctrl;

    localparam int BB     = 12;
    localparam int ADDR_W = 24;
    localparam logic [95:0] WDATA = 96'h00112233445566778899AABB;

`ifdef PSRAM_FAST_READ_EN
    localparam int         RD_LAT   = 546;
    localparam int         RD_RISES = 136;
    localparam logic [7:0] RD_OP    = 8'h0B;
    localparam int         RD_START = 40;
`else
    localparam int         RD_LAT   = 514;
    localparam int         RD_RISES = 128;
    localparam logic [7:0] RD_OP    = 8'h03;
    localparam int         RD_START = 32;
`endif

    logic clk;
    logic rst_n;
    logic init_done;
    logic ce;
    logic sclk;
    logic mosi;
    logic miso;

    int n_checks;
    int n_fail;

    psram_spi_ctrl_if #(.ADDR_W(ADDR_W), .BURST_BYTES(BB)) bus ();

    psram_spi_ctrl #(
        .BURST_BYTES    (BB),
        .ADDR_W         (ADDR_W),
        .CLK_DIV        (2),
        .INIT_CYCLES    (100),
        .CE_HIGH_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done),
        .ce        (ce),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural PSRAM model ----------------
    logic [7:0]  mem [0:1023];
    logic [7:0]  frame_bytes [$];
    logic [7:0]  m_op;
    logic [7:0]  m_shift;
    logic [23:0] m_addr;
    int          m_bits;
    int          m_rises;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    always @(negedge ce) begin
        m_bits  = 0;
        m_rises = 0;
        m_op    = 8'h00;
        frame_bytes.delete();
    end

    always @(posedge sclk) begin
        if (!ce) begin
            m_shift = {m_shift[6:0], mosi};
            m_bits++;
            m_rises++;
            if (m_bits % 8 == 0) begin
                frame_bytes.push_back(m_shift);
                if (m_bits == 8) begin
                    m_op = m_shift;
                end else if (m_bits <= 32) begin
                    m_addr = {m_addr[15:0], m_shift};
                end else if (m_op == 8'h02) begin
                    mem[10'(m_addr[9:0] + 10'((m_bits - 40) / 8))] = m_shift;
                end
            end
        end
    end

    always @(negedge sclk) begin
        if (!ce && (m_op == 8'h03 || m_op == 8'h0B)) begin
            int ds;
            int k;
            logic [7:0] b;
            ds = (m_op == 8'h0B) ? 40 : 32;
            if (m_bits >= ds) begin
                k    = m_bits - ds;
                b    = mem[10'(m_addr[9:0] + 10'(k / 8))];
                miso = b[7 - (k % 8)];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_request(input logic wr, input logic [23:0] addr, input logic [95:0] wd,
                              output int lat, output logic [95:0] rd, output bit acc_ok);
        int w;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        acc_ok = 1'b0;
        lat    = -1;
        rd     = '0;
        w      = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (bus.req_ready) acc_ok = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (acc_ok) begin
            for (int c = 1; c <= 1000; c++) begin
                @(negedge clk);
                if (bus.rsp_valid) begin
                    lat = c;
                    rd  = bus.rsp_rdata;
                    break;
                end
            end
        end
    endtask

    task automatic wait_ce(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (ce === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ce !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ce got %b want 1", ce); end
        n_checks++; if (sclk !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sclk got %b want 0", sclk); end
        n_checks++; if (mosi !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mosi got %b want 0", mosi); end
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_ready got %b want 0", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 96'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_init_done got %b want 0", init_done); end
    endtask

    task automatic test_init();
        int  fall_at;
        int  hi;
        bit  ok;
        @(negedge clk);
        rst_n   = 1'b1;
        fall_at = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (!ce) begin
                fall_at = k;
                break;
            end
        end
        n_checks++; if (fall_at != 100) begin n_fail++; $display("[TB] FAIL init_wait_len got %0d want 100", fall_at); end
        wait_ce(1'b1, 200, ok);
        n_checks++;
        if (!ok || frame_bytes.size() != 1 || frame_bytes[0] !== 8'h66 || m_rises != 8) begin
            n_fail++;
            $display("[TB] FAIL init_rsten_frame got %0d bytes first %h rises %0d want 1 byte 66 rises 8",
                     frame_bytes.size(), (frame_bytes.size() > 0) ? frame_bytes[0] : 8'hxx, m_rises);
        end
        hi = 1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (!ce) break;
            hi++;
        end
        n_checks++; if (hi != 4) begin n_fail++; $display("[TB] FAIL init_ce_gap got %0d want 4", hi); end
        wait_ce(1'b1, 200, ok);
        n_checks++;
        if (!ok || frame_bytes.size() != 1 || frame_bytes[0] !== 8'h99 || m_rises != 8) begin
            n_fail++;
            $display("[TB] FAIL init_rst_frame got %0d bytes first %h rises %0d want 1 byte 99 rises 8",
                     frame_bytes.size(), (frame_bytes.size() > 0) ? frame_bytes[0] : 8'hxx, m_rises);
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL init_done got 0 want 1"); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL init_req_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_write();
        int          lat;
        logic [95:0] rd;
        logic [95:0] wd;
        logic [7:0]  exp_b [16];
        bit          acc;
        int          bad;
        wd = WDATA;
        do_request(1'b1, 24'h000100, wd, lat, rd, acc);
        n_checks++; if (lat != 514) begin n_fail++; $display("[TB] FAIL write_latency got %0d want 514 (accepted %b)", lat, acc); end
        @(negedge clk);
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL write_rsp_pulse got %b want 0", bus.rsp_valid); end
        exp_b[0] = 8'h02; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'h00;
        for (int i = 0; i < 12; i++) exp_b[4 + i] = wd[95 - 8 * i -: 8];
        bad = 0;
        if (frame_bytes.size() != 16) bad = 1;
        else for (int i = 0; i < 16; i++) if (frame_bytes[i] !== exp_b[i]) bad = 1;
        n_checks++; if (bad != 0) begin n_fail++; $display("[TB] FAIL write_mosi_stream got %0d bytes %p want 16 bytes 02 00 01 00 00 11..BB", frame_bytes.size(), frame_bytes); end
        n_checks++; if (m_rises != 128) begin n_fail++; $display("[TB] FAIL write_sclk_rises got %0d want 128", m_rises); end
    endtask

    task automatic test_read();
        int          lat;
        logic [95:0] rd;
        bit          acc;
        do_request(1'b0, 24'h000100, 96'h0, lat, rd, acc);
        n_checks++; if (lat != RD_LAT) begin n_fail++; $display("[TB] FAIL read_latency got %0d want %0d (accepted %b)", lat, RD_LAT, acc); end
        n_checks++; if (rd !== WDATA) begin n_fail++; $display("[TB] FAIL read_data got %h want %h", rd, WDATA); end
        n_checks++; if (frame_bytes.size() == 0 || frame_bytes[0] !== RD_OP) begin n_fail++; $display("[TB] FAIL read_opcode got %h want %h", (frame_bytes.size() > 0) ? frame_bytes[0] : 8'hxx, RD_OP); end
        n_checks++; if (m_rises != RD_RISES) begin n_fail++; $display("[TB] FAIL read_sclk_rises got %0d want %0d", m_rises, RD_RISES); end
    endtask

    task automatic test_back_to_back();
        int n_acc;
        int viol;
        int t1;
        int t2;
        int hi_run;
        int hi_at_t2;
        int lat;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 24'h000200;
        bus.req_wdata = 96'hDEADBEEF0123456789ABCDEF;
        n_acc = 0; viol = 0; t1 = -1; t2 = -1; hi_run = 0; hi_at_t2 = -1;
        for (int c = 0; c < 1200 && n_acc < 2; c++) begin
            @(negedge clk);
            if (!ce && bus.req_ready) viol++;
            hi_run = ce ? hi_run + 1 : 0;
            if (bus.req_valid && bus.req_ready) begin
                n_acc++;
                if (n_acc == 1) t1 = c;
                else begin
                    t2       = c;
                    hi_at_t2 = hi_run;
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++; if (n_acc != 2 || t2 - t1 != 518) begin n_fail++; $display("[TB] FAIL b2b_accept_spacing got %0d accepts spacing %0d want 2 accepts spacing 518", n_acc, t2 - t1); end
        n_checks++; if (viol != 0) begin n_fail++; $display("[TB] FAIL b2b_ready_while_busy got %0d cycles want 0", viol); end
        n_checks++; if (hi_at_t2 < 4) begin n_fail++; $display("[TB] FAIL b2b_ce_high_before_second got %0d want >=4", hi_at_t2); end
        lat = -1;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = c;
                break;
            end
        end
        n_checks++; if (lat != 514) begin n_fail++; $display("[TB] FAIL b2b_second_latency got %0d want 514", lat); end
        n_checks++; if (bus.rsp_rdata !== WDATA) begin n_fail++; $display("[TB] FAIL b2b_rdata_held got %h want %h", bus.rsp_rdata, WDATA); end
    endtask

    task automatic test_page_wrap();
        int          lat;
        logic [95:0] rd;
        logic [95:0] exp_rd;
        bit          acc;
        for (int j = 0; j < 12; j++) exp_rd[95 - 8 * j -: 8] = pat((16'h03FC + j) & 16'h03FF);
        do_request(1'b0, 24'h0003FC, 96'h0, lat, rd, acc);
        n_checks++; if (lat != RD_LAT) begin n_fail++; $display("[TB] FAIL wrap_latency got %0d want %0d (accepted %b)", lat, RD_LAT, acc); end
        n_checks++; if (rd !== exp_rd) begin n_fail++; $display("[TB] FAIL wrap_data got %h want %h", rd, exp_rd); end
    endtask

    task automatic test_reset_abort();
        int rv_seen;
        int fall_at;
        bit ok;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 24'h000100;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rv_seen = 0;
        repeat (250) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_seen++;
        end
        for (int c = 0; c < 8 && !sclk; c++) @(negedge clk);
        n_checks++; if (!ok || sclk !== 1'b1 || ce !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_setup got accepted %b sclk %b ce %b want 1 1 0", ok, sclk, ce); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ce !== 1'b1 || sclk !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_immediate got ce %b sclk %b want 1 0", ce, sclk); end
        n_checks++; if (init_done !== 1'b0 || bus.req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flags got init_done %b req_ready %b want 0 0", init_done, bus.req_ready); end
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        fall_at = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) rv_seen++;
            if (!ce) begin
                fall_at = k;
                break;
            end
        end
        n_checks++; if (fall_at != 100) begin n_fail++; $display("[TB] FAIL abort_reinit_wait got %0d want 100", fall_at); end
        wait_ce(1'b1, 200, ok);
        n_checks++; if (!ok || frame_bytes.size() != 1 || frame_bytes[0] !== 8'h66) begin n_fail++; $display("[TB] FAIL abort_reinit_rsten got %0d bytes want 1 byte 66", frame_bytes.size()); end
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) rv_seen++;
            if (init_done) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++; if (!ok || bus.req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_reinit_done got init_done %b req_ready %b want 1 1", ok, bus.req_ready); end
        n_checks++; if (rv_seen != 0) begin n_fail++; $display("[TB] FAIL abort_no_rsp got %0d pulses want 0", rv_seen); end
        n_checks++; if (bus.rsp_rdata !== 96'h0) begin n_fail++; $display("[TB] FAIL abort_rdata_cleared got %h want 0", bus.rsp_rdata); end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        miso          = 1'b0;
        m_op          = 8'h00;
        m_shift       = 8'h00;
        m_addr        = 24'h0;
        m_bits        = 0;
        m_rises       = 0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);

        test_reset();
        test_init();
        test_write();
        test_read();
        test_back_to_back();
        test_page_wrap();
        test_reset_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
